// File: rtl/dcu_pkg.sv
// Shared types, default widths and saturating add for the distance calculation unit.
package dcu_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } dcu_state_e;

  localparam int BIN_W  = 8;
  localparam int ADDR_W = 21;
  localparam int DIST_W = 18;

  // Unsigned add clamped at max. Operands are widened to 32 bits so one
  // function serves every DIST_W/BIN_W combination up to 31-bit distances.
  function automatic logic [31:0] sat_add(input logic [31:0] acc,
                                          input logic [31:0] inc,
                                          input logic [31:0] max);
    logic [32:0] sum;
    sum = {1'b0, acc} + {1'b0, inc};
    return (sum > {1'b0, max}) ? max : sum[31:0];
  endfunction

endpackage

// File: rtl/dcu_abs_diff.sv
// Combinational |a-b| for one bin pair. The subtraction is carried one bit
// wider than the operands so the sign is explicit; the magnitude always fits BIN_W.
module dcu_abs_diff #(
  parameter int BIN_W = 8
) (
  input  logic [BIN_W-1:0] a,
  input  logic [BIN_W-1:0] b,
  output logic [BIN_W-1:0] diff
);

  logic [BIN_W:0] d;

  // Signed difference, then fold negative results back to their magnitude.
  always_comb begin
    d    = {1'b0, a} - {1'b0, b};
    diff = d[BIN_W] ? BIN_W'(-d) : d[BIN_W-1:0];
  end

endmodule

// File: rtl/distance_calc_unit.sv
// L1 histogram distance engine. On a request it streams NUM_BINS bins of the
// stored histogram and the query histogram, accumulates |hist-query| with
// saturation, and reports the sum with a one-cycle dcu_valid strobe.
module distance_calc_unit
  import dcu_pkg::*;
#(
  parameter int NUM_BINS = 256,
  parameter int BIN_W    = dcu_pkg::BIN_W,
  parameter int ADDR_W   = dcu_pkg::ADDR_W,
  parameter int QADDR_W  = 8,
  parameter int DIST_W   = dcu_pkg::DIST_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               dcu_enable,
  input  logic [ADDR_W-1:0]  hist_addr_offset,
  output logic               hist_ren,
  output logic [ADDR_W-1:0]  hist_addr,
  input  logic [BIN_W-1:0]   hist_rdata,
  output logic               q_ren,
  output logic [QADDR_W-1:0] q_addr,
  input  logic [BIN_W-1:0]   q_rdata,
  output logic               dcu_busy,
  output logic               dcu_valid,
  output logic [DIST_W-1:0]  distance
);

  localparam int                CNT_W    = (NUM_BINS > 1) ? $clog2(NUM_BINS) : 1;
  localparam logic [CNT_W-1:0]  LAST_BIN = CNT_W'(NUM_BINS - 1);
  localparam logic [DIST_W-1:0] ACC_MAX  = '1;

  dcu_state_e        state;
  logic [CNT_W-1:0]  bin_cnt;
  logic [DIST_W-1:0] acc;
  logic [DIST_W-1:0] acc_nxt;
  logic              data_vld;
  logic              accept;
  logic [BIN_W-1:0]  bin_diff;

  dcu_abs_diff #(.BIN_W(BIN_W)) u_abs_diff (
    .a    (hist_rdata),
    .b    (q_rdata),
    .diff (bin_diff)
  );

  // Requests are only taken when no read stream is in flight (IDLE or DONE).
  always_comb begin
    accept  = dcu_enable && (state == IDLE || state == DONE);
    acc_nxt = data_vld ? DIST_W'(sat_add(32'(acc), 32'(bin_diff), 32'(ACC_MAX))) : acc;
  end

  // Memory read data lands one cycle after the read enable; track that here.
  always_ff @(posedge clk) begin
    if (rst) data_vld <= 1'b0;
    else     data_vld <= hist_ren;
  end

  // Job sequencer: accept, stream reads, drain the last bin, publish result.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      bin_cnt   <= '0;
      acc       <= '0;
      hist_ren  <= 1'b0;
      q_ren     <= 1'b0;
      hist_addr <= '0;
      q_addr    <= '0;
      dcu_busy  <= 1'b0;
      dcu_valid <= 1'b0;
      distance  <= '0;
    end else begin
      dcu_valid <= 1'b0;
      if (accept) begin
        // Base address is captured here; later offset changes are ignored.
        state     <= READ;
        bin_cnt   <= '0;
        acc       <= '0;
        hist_ren  <= 1'b1;
        q_ren     <= 1'b1;
        hist_addr <= hist_addr_offset;
        q_addr    <= '0;
        dcu_busy  <= 1'b1;
      end else begin
        unique case (state)
          READ: begin
            acc <= acc_nxt;
            if (bin_cnt == LAST_BIN) begin
              hist_ren <= 1'b0;
              q_ren    <= 1'b0;
              state    <= DRAIN;
            end else begin
              bin_cnt   <= bin_cnt + CNT_W'(1);
              hist_addr <= hist_addr + ADDR_W'(1);
              q_addr    <= q_addr + QADDR_W'(1);
            end
          end
          DRAIN: begin
            // Last bin arrives now; fold it in and publish in the same edge.
            acc       <= acc_nxt;
            distance  <= acc_nxt;
            dcu_valid <= 1'b1;
            state     <= DONE;
          end
          DONE: begin
            dcu_busy <= 1'b0;
            state    <= IDLE;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_distance_calc_unit.sv
// Self-checking bench: randomized histograms, behavioural memories with one
// cycle read latency, and an arithmetic L1 reference model.
module tb_distance_calc_unit;

  localparam int N  = 256;
  localparam int AW = 21;
  localparam int BW = 8;
  localparam int DW = 18;
  localparam int NB = 1024;

  logic          clk = 1'b0;
  logic          rst;
  logic          dcu_enable;
  logic [AW-1:0] hist_addr_offset;
  logic          hist_ren, q_ren, dcu_busy, dcu_valid;
  logic [AW-1:0] hist_addr;
  logic [7:0]    q_addr;
  logic [BW-1:0] hist_rdata = '0, q_rdata = '0;
  logic [DW-1:0] distance;

  logic          en_b;
  logic          hist_ren_b, q_ren_b, busy_b, valid_b;
  logic [AW-1:0] hist_addr_b;
  logic [9:0]    q_addr_b;
  logic [9:0]    hist_rdata_b = '0, q_rdata_b = '0;
  logic [DW-1:0] distance_b;

  int vectors = 0;
  int miscompares = 0;
  int prev_dist = 0;
  logic [AW-1:0] first_addr [3];

  logic [BW-1:0] hmem [int unsigned];
  logic [BW-1:0] qmem [N];

  always #5 clk = ~clk;

  distance_calc_unit dut (
    .clk(clk), .rst(rst), .dcu_enable(dcu_enable), .hist_addr_offset(hist_addr_offset),
    .hist_ren(hist_ren), .hist_addr(hist_addr), .hist_rdata(hist_rdata),
    .q_ren(q_ren), .q_addr(q_addr), .q_rdata(q_rdata),
    .dcu_busy(dcu_busy), .dcu_valid(dcu_valid), .distance(distance)
  );

  distance_calc_unit #(.NUM_BINS(NB), .BIN_W(10), .QADDR_W(10)) dut_b (
    .clk(clk), .rst(rst), .dcu_enable(en_b), .hist_addr_offset(21'h0),
    .hist_ren(hist_ren_b), .hist_addr(hist_addr_b), .hist_rdata(hist_rdata_b),
    .q_ren(q_ren_b), .q_addr(q_addr_b), .q_rdata(q_rdata_b),
    .dcu_busy(busy_b), .dcu_valid(valid_b), .distance(distance_b)
  );

  // Behavioural memories: data for a read appears on the following cycle.
  always @(posedge clk) begin
    if (hist_ren) hist_rdata <= hmem.exists(32'(hist_addr)) ? hmem[32'(hist_addr)] : '0;
    if (q_ren)    q_rdata    <= qmem[q_addr];
    if (hist_ren_b) hist_rdata_b <= 10'h3FF;
    if (q_ren_b)    q_rdata_b    <= 10'h000;
  end

  task automatic check(input string tag, input longint obs, input longint exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int unsigned key(input logic [AW-1:0] base, input int i);
    logic [AW-1:0] a;
    a = AW'(32'(base) + i);
    return 32'(a);
  endfunction

  // Reference: plain sum of absolute bin differences, clamped to DW bits.
  function automatic int ref_dist(input logic [AW-1:0] base);
    int s = 0;
    for (int i = 0; i < N; i++) begin
      int h, q;
      h = hmem.exists(key(base, i)) ? int'(hmem[key(base, i)]) : 0;
      q = int'(qmem[i]);
      s += (h > q) ? h - q : q - h;
    end
    if (s > (1 << DW) - 1) s = (1 << DW) - 1;
    return s;
  endfunction

  // mode 0: query equals hist; 1: independent random; 2: hist 255, query 0
  task automatic fill(input logic [AW-1:0] base, input int mode);
    hmem.delete();
    for (int i = 0; i < N; i++) begin
      logic [BW-1:0] h;
      h = (mode == 2) ? 8'hFF : BW'($urandom);
      hmem[key(base, i)] = h;
      qmem[i] = (mode == 0) ? h : (mode == 2) ? 8'h00 : BW'($urandom);
    end
  endtask

  // One request at cycle 0; optional ignored/extra enable, back-to-back hold
  // in DONE, and reset at cycle rst_c. Offset is scrambled whenever it should
  // not matter.
  task automatic run_job(input string tag, input logic [AW-1:0] base,
                         input int pulse_c, input bit hold, input int rst_c);
    int exp_dist, last, ren_err, busy_err, vld_err, dist_err, vcnt;
    exp_dist = ref_dist(base);
    last = hold ? 2*N + 4 : N + 2;
    ren_err = 0; busy_err = 0; vld_err = 0; dist_err = 0; vcnt = 0;
    @(negedge clk);
    dcu_enable = 1'b1;
    hist_addr_offset = base;
    @(posedge clk); #1;
    for (int c = 1; c <= last + 3; c++) begin
      bit dead, act, e_busy, e_vld;
      int idx, e_dist;
      dcu_enable = (c == pulse_c) || (hold && c == N + 2);
      hist_addr_offset = (hold && c == N + 2) ? base : AW'($urandom);
      rst = (c == rst_c);
      @(negedge clk);
      dead = (rst_c > 0) && (c > rst_c);
      act = 1'b0; idx = 0;
      if (!dead) begin
        if (c <= N) begin act = 1'b1; idx = c - 1; end
        else if (hold && c >= N + 3 && c <= 2*N + 2) begin act = 1'b1; idx = c - N - 3; end
      end
      e_busy = !dead && ((c <= N + 2) || (hold && c <= 2*N + 4));
      e_vld  = !dead && ((c == N + 2) || (hold && c == 2*N + 4));
      e_dist = dead ? 0 : (c >= N + 2) ? exp_dist : prev_dist;
      if (hist_ren !== act || q_ren !== act) ren_err++;
      if (act && (hist_addr !== AW'(32'(base) + idx) || q_addr !== 8'(idx))) ren_err++;
      if (dead && (hist_addr !== '0 || q_addr !== '0)) ren_err++;
      if (c <= 3) first_addr[c-1] = hist_addr;
      if (dcu_busy !== e_busy) busy_err++;
      if (dcu_valid !== e_vld) vld_err++;
      if (dcu_valid === 1'b1) vcnt++;
      if (32'(distance) !== e_dist) dist_err++;
      @(posedge clk); #1;
    end
    rst = 1'b0;
    dcu_enable = 1'b0;
    check({tag, ".ren_addr_errs"}, ren_err, 0);
    check({tag, ".busy_errs"}, busy_err, 0);
    check({tag, ".valid_timing_errs"}, vld_err, 0);
    check({tag, ".valid_count"}, vcnt, (rst_c > 0) ? 0 : hold ? 2 : 1);
    check({tag, ".distance_errs"}, dist_err, 0);
    prev_dist = (rst_c > 0) ? 0 : exp_dist;
  endtask

  initial begin
    logic [AW-1:0] base;
    int st_err, cyc;
    rst = 1'b1;
    dcu_enable = 1'b1;
    en_b = 1'b0;
    hist_addr_offset = 21'h1ABCDE;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst.valid", dcu_valid, 0);
    check("rst.busy", dcu_busy, 0);
    check("rst.hist_ren", hist_ren, 0);
    check("rst.q_ren", q_ren, 0);
    check("rst.hist_addr", hist_addr, 0);
    check("rst.q_addr", q_addr, 0);
    check("rst.distance", distance, 0);
    rst = 1'b0;
    dcu_enable = 1'b0;

    base = AW'($urandom);
    fill(base, 0);
    run_job("equal", base, 0, 1'b0, 0);
    check("equal.distance", distance, 0);

    base = AW'($urandom);
    fill(base, 1);
    run_job("random", base, 0, 1'b0, 0);

    base = 21'h001000;
    fill(base, 2);
    run_job("max_bins", base, 0, 1'b0, 0);
    check("max_bins.distance", distance, 65280);

    base = 21'h1FFFFE;
    fill(base, 1);
    run_job("wrap", base, 0, 1'b0, 0);
    check("wrap.addr0", first_addr[0], 21'h1FFFFE);
    check("wrap.addr1", first_addr[1], 21'h1FFFFF);
    check("wrap.addr2", first_addr[2], 21'h000000);

    base = AW'($urandom);
    fill(base, 1);
    run_job("pulse_mid_read", base, 100, 1'b0, 0);
    run_job("back_to_back", base, 0, 1'b1, 0);
    run_job("reset_mid_job", base, 100, 1'b0, 100);
    run_job("after_reset", base, 0, 1'b0, 0);

    // Idle with a wandering offset must leave the result untouched.
    st_err = 0;
    for (int c = 0; c < 20; c++) begin
      hist_addr_offset = AW'($urandom);
      @(negedge clk);
      if (32'(distance) !== prev_dist || dcu_valid !== 1'b0 || dcu_busy !== 1'b0) st_err++;
      @(posedge clk); #1;
    end
    check("idle_stable", st_err, 0);

    // Wide instance: 1024 bins of 1023 against zeros must clamp.
    @(negedge clk);
    en_b = 1'b1;
    @(posedge clk); #1;
    en_b = 1'b0;
    cyc = 0;
    for (int c = 1; c <= NB + 20; c++) begin
      @(negedge clk);
      if (valid_b === 1'b1) begin cyc = c; break; end
      @(posedge clk); #1;
    end
    check("sat.valid_cycle", cyc, NB + 2);
    check("sat.distance", distance_b, 262143);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
